sti_rx: RTL and testbench
=========================

Name: sti_rx

Overview:
- Serial-to-parallel receiver at the far end of the STI serial link; the inverse of the STI_DAC serializer.
- Consumes the so_data/so_valid bit stream and uses the same per-frame format controls: length, fill, msb-first, low-byte.
- Rebuilds the original 16-bit parallel word, strips fill bits, flags framing and pad errors, and counts frames.
- Feeds a downstream loopback checker and pixel reconstruction.

Parameters:
- FCNT_W, 8, width of the received-frame counter; wraps modulo 2^FCNT_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_load  in  1  one-cycle strobe; latches cfg_length/cfg_fill/cfg_msb/cfg_low.
- cfg_length  in  2  frame length: 00=8, 01=16, 10=24, 11=32 bits.
- cfg_fill  in  1  for 24/32-bit frames: 1=payload at MSB end, 0=payload at LSB end.
- cfg_msb  in  1  1=bits arrive MSB first, 0=LSB first.
- cfg_low  in  1  8-bit frames: 1=byte maps to po_data[15:8], 0=byte maps to po_data[7:0].
- rx_end  in  1  level; high means the frame in progress is the last one.
- si_data  in  1  serial data bit.
- si_valid  in  1  serial bit qualifier.
- po_data  out  16  recovered parallel word.
- po_valid  out  1  one-cycle pulse; po_data valid.
- pad_err  out  1  qualified by po_valid; a fill bit was nonzero.
- frame_err  out  1  one-cycle pulse; frame truncated.
- rx_busy  out  1  high in RECV.
- rx_finish  out  1  sticky; last frame received.
- frame_cnt  out  FCNT_W  count of good frames (po_valid pulses).

Behaviour:
- Reset (async, reset=0): state=IDLE; po_data=0; po_valid=0; pad_err=0; frame_err=0; rx_busy=0; rx_finish=0; frame_cnt=0; latched config=0 (8-bit, LSB first, low=0); bit counter=0; word register W[31:0]=0.
- Config latch:
  - cfg_load is honoured only in IDLE and ignored in RECV and FINISH.
  - If cfg_load and the first si_valid coincide in IDLE, the new config applies to that frame.
- N = 8, 16, 24 or 32 per latched length.
- States: IDLE, RECV, FINISH.
- IDLE:
  - On si_valid: W cleared, first bit stored, cnt=1, go RECV.
  - If N were 1 the frame would end here; N is never 1, so this case does not arise.
- RECV, each si_valid cycle: store the bit and cnt++.
  - Bit index for sample k (k=0..N-1): N-1-k if msb-first, k if LSB-first.
- RECV completion: on the si_valid cycle where the Nth bit is sampled:
  - Next cycle: po_valid=1, po_data and pad_err updated, frame_cnt++.
  - Latency = 1 cycle after the last bit.
  - Next state is FINISH if rx_end was high at that edge, else IDLE.
- Back-to-back frames: si_valid in the cycle immediately after completion starts a new frame (IDLE accepts it), with no lost bit.
- Truncation: si_valid low in RECV before N bits:
  - frame_err pulses 1 cycle; no po_valid; frame_cnt unchanged; return to IDLE.
- Extraction:
  - len 8: b=W[7:0]; po_data = cfg_low ? {b,8'h00} : {8'h00,b}; pad_err=0.
  - len 16: po_data=W[15:0]; pad_err=0.
  - len 24, fill=1: po_data=W[23:8]; pad_err=|W[7:0].
  - len 24, fill=0: po_data=W[15:0]; pad_err=|W[23:16].
  - len 32, fill=1: po_data=W[31:16]; pad_err=|W[15:0].
  - len 32, fill=0: po_data=W[15:0]; pad_err=|W[31:16].
- po_data holds its last value between pulses; pad_err clears when po_valid is low.
- frame_cnt wraps from 2^FCNT_W-1 to 0 with no flag.
- FINISH: rx_finish=1 and is held; si_valid and cfg_load are ignored; leave only via reset.
- Reset mid-frame: the partial frame is discarded, with no po_valid and no frame_err.

Test Plan:
- Basic 16-bit: cfg len=01 msb=1, serial 16'hA5C3 MSB first → po_valid 1 cycle after 16th bit, po_data=16'hA5C3, pad_err=0, frame_cnt=1.
- 8-bit modes: len=00 low=1 lsb-first byte 8'h3C → po_data=16'h3C00; then low=0 → 16'h003C.
- Fill variants:
  - len=11 fill=1 msb-first {16'hBEEF,16'h0000} → po_data=16'hBEEF, pad_err=0.
  - len=10 fill=0 {8'h01,16'h1234} → po_data=16'h1234, pad_err=1.
- Truncation and recovery: len=01, si_valid dropped after 9 bits → frame_err pulse, no po_valid, frame_cnt unchanged. Next full frame 16'h0F0F is received correctly.
- Back-to-back plus end: two contiguous 24-bit frames with no gap, rx_end high during the second → two po_valid pulses exactly 24 cycles apart, then rx_finish=1. Further si_valid is ignored and frame_cnt stays at 2.
- Wrap and reset: 256 good 8-bit frames → frame_cnt=0. Async reset asserted mid-RECV → all outputs 0 immediately, no po_valid.

Source files
------------

// File: rtl/sti_rx.sv
// ----------------------------------------------------------------------------
// sti_rx -- STI serial link receiver (serial-to-parallel).
//
// Rebuilds the 16-bit parallel word sent by the STI serializer. Each frame is
// 8, 16, 24 or 32 bits long, arrives MSB- or LSB-first and, for 24/32-bit
// frames, carries fill bits at one end. Fill bits are stripped and checked to
// be zero, truncated frames are flagged, and good frames are counted.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   cfg_load    one-cycle strobe latching cfg_* (honoured in IDLE only)
//   cfg_length  frame length code: 0=8, 1=16, 2=24, 3=32 bits
//   cfg_fill    24/32-bit frames: 1=payload at MSB end, 0=payload at LSB end
//   cfg_msb     1=bits arrive MSB first, 0=LSB first
//   cfg_low     8-bit frames: 1=byte to po_data[15:8], 0=byte to po_data[7:0]
//   rx_end      level; high while the last frame is being received
//   si_data     serial data bit
//   si_valid    serial bit qualifier
//   po_data     recovered word, held between pulses
//   po_valid    one-cycle pulse, po_data valid
//   pad_err     qualified by po_valid; a fill bit was nonzero
//   frame_err   one-cycle pulse; frame truncated
//   rx_busy     high while a frame is in progress
//   rx_finish   sticky; last frame received, receiver halted until reset
//   frame_cnt   count of good frames, wraps modulo 2^FCNT_W
// ----------------------------------------------------------------------------
module sti_rx #(
   parameter int FCNT_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_load,
   input  logic [1:0]        cfg_length,
   input  logic              cfg_fill,
   input  logic              cfg_msb,
   input  logic              cfg_low,
   input  logic              rx_end,
   input  logic              si_data,
   input  logic              si_valid,
   output logic [15:0]       po_data,
   output logic              po_valid,
   output logic              pad_err,
   output logic              frame_err,
   output logic              rx_busy,
   output logic              rx_finish,
   output logic [FCNT_W-1:0] frame_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECV   = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   state_t state_reg, state_next;

   // latched frame format
   logic [1:0] len_reg, len_next;
   logic       fill_reg, fill_next;
   logic       msb_reg, msb_next;
   logic       low_reg, low_next;

   // number of bits already stored in the current frame
   logic [4:0] cnt_reg, cnt_next;

   // frame assembly register
   logic [31:0] w_reg, w_next;

   logic [15:0]       po_data_reg, po_data_next;
   logic              po_valid_reg, po_valid_next;
   logic              pad_err_reg, pad_err_next;
   logic              frame_err_reg, frame_err_next;
   logic              finish_reg, finish_next;
   logic [FCNT_W-1:0] fcnt_reg, fcnt_next;

   // ------------------------------------------------------------------------
   // Bit placement
   // ------------------------------------------------------------------------
   // A cfg_load coinciding with the first bit in IDLE must already steer that
   // bit, so the effective format bypasses the latch in that cycle.
   logic       take_cfg;
   logic [1:0] eff_len;
   logic       eff_msb;
   logic [4:0] last_idx;
   logic [4:0] samp_k;
   logic [4:0] wr_idx;
   logic       wr_en;
   logic       w_clear;

   assign take_cfg = (state_reg == ST_IDLE) && cfg_load;
   assign eff_len  = take_cfg ? cfg_length : len_reg;
   assign eff_msb  = take_cfg ? cfg_msb    : msb_reg;

   // N-1 = 8*len + 7, i.e. the length code followed by three ones
   assign last_idx = {eff_len, 3'b111};

   // sample index k of the bit on si_data this cycle
   assign samp_k   = (state_reg == ST_IDLE) ? 5'd0 : cnt_reg;
   assign wr_idx   = eff_msb ? (last_idx - samp_k) : samp_k;

   assign wr_en    = si_valid && (state_reg != ST_FINISH);
   assign w_clear  = si_valid && (state_reg == ST_IDLE);

   // Per-bit next value: the addressed bit takes si_data; a new frame clears
   // every other bit so stale data never leaks into the fill check.
   for (genvar gi = 0; gi < 32; gi++) begin : g_wbit
      assign w_next[gi] = (wr_en && (wr_idx == 5'(gi))) ? si_data :
                          (w_clear ? 1'b0 : w_reg[gi]);
   end

   // ------------------------------------------------------------------------
   // Payload extraction: returns {pad_err, po_data}
   // ------------------------------------------------------------------------
   function automatic logic [16:0] extract(
      input logic [31:0] w,
      input logic [1:0]  len,
      input logic        fill,
      input logic        low
   );
      logic [16:0] r;
      r = '0;
      case (len)
         2'd0:    r = {1'b0, (low ? {w[7:0], 8'h00} : {8'h00, w[7:0]})};
         2'd1:    r = {1'b0, w[15:0]};
         2'd2:    r = fill ? {|w[7:0],   w[23:8]}  : {|w[23:16], w[15:0]};
         default: r = fill ? {|w[15:0],  w[31:16]} : {|w[31:16], w[15:0]};
      endcase
      return r;
   endfunction

   // Extraction looks at w_next so the word is complete on the edge that
   // samples the last bit, giving a single cycle of latency.
   logic [16:0] ext;
   assign ext = extract(w_next, len_reg, fill_reg, low_reg);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= ST_IDLE;
         len_reg       <= 2'd0;
         fill_reg      <= 1'b0;
         msb_reg       <= 1'b0;
         low_reg       <= 1'b0;
         cnt_reg       <= 5'd0;
         w_reg         <= 32'd0;
         po_data_reg   <= 16'd0;
         po_valid_reg  <= 1'b0;
         pad_err_reg   <= 1'b0;
         frame_err_reg <= 1'b0;
         finish_reg    <= 1'b0;
         fcnt_reg      <= '0;
      end else begin
         state_reg     <= state_next;
         len_reg       <= len_next;
         fill_reg      <= fill_next;
         msb_reg       <= msb_next;
         low_reg       <= low_next;
         cnt_reg       <= cnt_next;
         w_reg         <= w_next;
         po_data_reg   <= po_data_next;
         po_valid_reg  <= po_valid_next;
         pad_err_reg   <= pad_err_next;
         frame_err_reg <= frame_err_next;
         finish_reg    <= finish_next;
         fcnt_reg      <= fcnt_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state / output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      len_next       = len_reg;
      fill_next      = fill_reg;
      msb_next       = msb_reg;
      low_next       = low_reg;
      cnt_next       = cnt_reg;
      po_data_next   = po_data_reg;
      po_valid_next  = 1'b0;
      pad_err_next   = 1'b0;
      frame_err_next = 1'b0;
      finish_next    = finish_reg;
      fcnt_next      = fcnt_reg;

      case (state_reg)
         ST_IDLE: begin
            if (cfg_load) begin
               len_next  = cfg_length;
               fill_next = cfg_fill;
               msb_next  = cfg_msb;
               low_next  = cfg_low;
            end
            // frames are at least 8 bits, so the first bit never completes one
            if (si_valid) begin
               cnt_next   = 5'd1;
               state_next = ST_RECV;
            end
         end

         ST_RECV: begin
            if (si_valid) begin
               if (cnt_reg == last_idx) begin
                  po_valid_next = 1'b1;
                  po_data_next  = ext[15:0];
                  pad_err_next  = ext[16];
                  fcnt_next     = fcnt_reg + FCNT_W'(1);
                  cnt_next      = 5'd0;
                  if (rx_end) begin
                     finish_next = 1'b1;
                     state_next  = ST_FINISH;
                  end else begin
                     state_next  = ST_IDLE;
                  end
               end else begin
                  cnt_next = cnt_reg + 5'd1;
               end
            end else begin
               // bit stream stopped before the frame was complete
               frame_err_next = 1'b1;
               cnt_next       = 5'd0;
               state_next     = ST_IDLE;
            end
         end

         ST_FINISH: begin
            // terminal: only reset leaves this state
            state_next = ST_FINISH;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign po_data   = po_data_reg;
   assign po_valid  = po_valid_reg;
   assign pad_err   = pad_err_reg;
   assign frame_err = frame_err_reg;
   assign rx_busy   = (state_reg == ST_RECV);
   assign rx_finish = finish_reg;
   assign frame_cnt = fcnt_reg;

endmodule

// File: tb/tb_sti_rx.sv
// ----------------------------------------------------------------------------
// tb_sti_rx -- self-checking bench for sti_rx.
//
// The reference model works in the serializer's direction: it builds the
// frame value from payload and fill (payload at the chosen end), shifts it out
// MSB- or LSB-first, and predicts po_data/pad_err, pulse timing, frame and
// error counts. A monitor records every po_valid/frame_err seen on the DUT.
// ----------------------------------------------------------------------------
module tb_sti_rx;

   localparam int FCNT_W = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              cfg_load = 1'b0;
   logic [1:0]        cfg_length = 2'd0;
   logic              cfg_fill = 1'b0;
   logic              cfg_msb = 1'b0;
   logic              cfg_low = 1'b0;
   logic              rx_end = 1'b0;
   logic              si_data = 1'b0;
   logic              si_valid = 1'b0;
   logic [15:0]       po_data;
   logic              po_valid;
   logic              pad_err;
   logic              frame_err;
   logic              rx_busy;
   logic              rx_finish;
   logic [FCNT_W-1:0] frame_cnt;

   always #5 clk = ~clk;

   sti_rx #(.FCNT_W(FCNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .cfg_load   (cfg_load),
      .cfg_length (cfg_length),
      .cfg_fill   (cfg_fill),
      .cfg_msb    (cfg_msb),
      .cfg_low    (cfg_low),
      .rx_end     (rx_end),
      .si_data    (si_data),
      .si_valid   (si_valid),
      .po_data    (po_data),
      .po_valid   (po_valid),
      .pad_err    (pad_err),
      .frame_err  (frame_err),
      .rx_busy    (rx_busy),
      .rx_finish  (rx_finish),
      .frame_cnt  (frame_cnt)
   );

   typedef struct {
      logic [15:0] data;
      logic        pad;
      int          cyc;
   } ev_t;

   ev_t mon_q[$];
   ev_t exp_q[$];

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int mon_ferr = 0;
   int exp_ferr = 0;

   // reference model state
   logic [FCNT_W-1:0] exp_cnt = '0;
   logic [15:0]       last_data = 16'd0;
   bit                exp_fin = 1'b0;
   logic [1:0]        m_len = 2'd0;
   bit                m_fill = 1'b0;
   bit                m_msb = 1'b0;
   bit                m_low = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      ev_t e;
      if (reset && po_valid) begin
         e.data = po_data;
         e.pad  = pad_err;
         e.cyc  = cyc;
         mon_q.push_back(e);
      end
      if (reset && frame_err) mon_ferr++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      exp_cnt   = '0;
      last_data = 16'd0;
      exp_fin   = 1'b0;
      m_len     = 2'd0;
      m_fill    = 1'b0;
      m_msb     = 1'b0;
      m_low     = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_data"},  po_data,   0);
      check({tag, "_valid"}, po_valid,  0);
      check({tag, "_pad"},   pad_err,   0);
      check({tag, "_ferr"},  frame_err, 0);
      check({tag, "_busy"},  rx_busy,   0);
      check({tag, "_fin"},   rx_finish, 0);
      check({tag, "_cnt"},   frame_cnt, 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 reset = 1'b0;
      #1 check_all_zero("rst");
      si_valid = 1'b0;
      cfg_load = 1'b0;
      rx_end   = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      model_clear();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         si_valid = 1'b0;
         cfg_load = 1'b0;
         rx_end   = 1'b0;
         si_data  = 1'($urandom);
      end
   endtask

   // Compare everything the monitor collected against the model.
   task automatic drain();
      ev_t e;
      ev_t m;
      #1;
      check("npulse", mon_q.size(), exp_q.size());
      while (exp_q.size() > 0 && mon_q.size() > 0) begin
         e = exp_q.pop_front();
         m = mon_q.pop_front();
         check("data", m.data, e.data);
         check("pad",  m.pad,  e.pad);
         check("lat",  m.cyc,  e.cyc);
      end
      exp_q.delete();
      mon_q.delete();
      check("fcnt",   frame_cnt, exp_cnt);
      check("ferr",   mon_ferr,  exp_ferr);
      check("hold",   po_data,   last_data);
      check("finish", rx_finish, exp_fin);
      check("idle_busy", rx_busy, 0);
   endtask

   // mode: 0 = keep current config, 1 = load in a separate cycle first,
   //       2 = load together with the first bit.
   // glitch: bit index (>=1) at which a stray cfg_load is driven mid-frame.
   task automatic send_frame(input int mode, input logic [1:0] len, input bit fill,
                             input bit msb, input bit low, input logic [15:0] pl,
                             input logic [15:0] pad_in, input int nsend,
                             input bit end_lvl, input int glitch);
      int          n;
      int          lastc;
      logic [31:0] f;
      logic [15:0] exp_d;
      bit          exp_p;
      ev_t         e;
      lastc = 0;
      if (mode == 1) begin
         @(negedge clk);
         si_valid   = 1'b0;
         cfg_load   = 1'b1;
         cfg_length = len;
         cfg_fill   = fill;
         cfg_msb    = msb;
         cfg_low    = low;
      end
      if (mode != 0) begin
         m_len  = len;
         m_fill = fill;
         m_msb  = msb;
         m_low  = low;
      end
      n = 8 * (int'(m_len) + 1);
      case (m_len)
         2'd0: begin
            f     = {24'h0, pl[7:0]};
            exp_d = m_low ? {pl[7:0], 8'h00} : {8'h00, pl[7:0]};
            exp_p = 1'b0;
         end
         2'd1: begin
            f     = {16'h0, pl};
            exp_d = pl;
            exp_p = 1'b0;
         end
         2'd2: begin
            f     = m_fill ? {8'h0, pl, pad_in[7:0]} : {8'h0, pad_in[7:0], pl};
            exp_d = pl;
            exp_p = (pad_in[7:0] != 8'h00);
         end
         default: begin
            f     = m_fill ? {pl, pad_in} : {pad_in, pl};
            exp_d = pl;
            exp_p = (pad_in != 16'h0000);
         end
      endcase
      for (int k = 0; k < nsend; k++) begin
         @(negedge clk);
         if (k == 1) check("busy", rx_busy, 1);
         si_valid = 1'b1;
         si_data  = m_msb ? f[n-1-k] : f[k];
         rx_end   = end_lvl;
         if (k == 0 && mode == 2) begin
            cfg_load   = 1'b1;
            cfg_length = len;
            cfg_fill   = fill;
            cfg_msb    = msb;
            cfg_low    = low;
         end else if (k > 0 && k == glitch) begin
            cfg_load   = 1'b1;
            cfg_length = 2'($urandom);
            cfg_fill   = 1'($urandom);
            cfg_msb    = 1'($urandom);
            cfg_low    = 1'($urandom);
         end else begin
            cfg_load = 1'b0;
         end
         lastc = cyc;
      end
      if (nsend == n) begin
         e.data = exp_d;
         e.pad  = exp_p;
         e.cyc  = lastc + 1;
         exp_q.push_back(e);
         exp_cnt++;
         last_data = exp_d;
         if (end_lvl) exp_fin = 1'b1;
      end else begin
         exp_ferr++;
      end
   endtask

   initial begin
      int        mode;
      int        prev_b2b;
      int        n;
      int        nsend;
      bit        trunc;
      bit        b2b;
      logic [1:0] len;
      logic [15:0] pad;

      do_reset();

      // directed cases
      send_frame(1, 2'd1, 1'b0, 1'b1, 1'b0, 16'hA5C3, 16'h0, 16, 1'b0, -1);
      idle(2); drain();
      send_frame(1, 2'd0, 1'b0, 1'b0, 1'b1, 16'h003C, 16'h0, 8, 1'b0, -1);
      idle(2); drain();
      send_frame(1, 2'd0, 1'b0, 1'b0, 1'b0, 16'h003C, 16'h0, 8, 1'b0, -1);
      idle(2); drain();
      send_frame(1, 2'd3, 1'b1, 1'b1, 1'b0, 16'hBEEF, 16'h0000, 32, 1'b0, -1);
      idle(2); drain();
      send_frame(1, 2'd2, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0001, 24, 1'b0, -1);
      idle(2); drain();
      send_frame(1, 2'd1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0, 9, 1'b0, -1);
      idle(2); drain();
      send_frame(0, 2'd1, 1'b0, 1'b1, 1'b0, 16'h0F0F, 16'h0, 16, 1'b0, -1);
      idle(2); drain();

      // randomized frames
      prev_b2b = 0;
      for (int i = 0; i < 60; i++) begin
         len  = 2'($urandom);
         mode = $urandom_range(0, 2);
         if (prev_b2b != 0 && mode == 1) mode = 2;
         n     = 8 * (int'((mode == 0) ? m_len : len) + 1);
         trunc = ($urandom_range(0, 5) == 0);
         nsend = trunc ? $urandom_range(1, n - 1) : n;
         pad   = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
         send_frame(mode, len, 1'($urandom), 1'($urandom), 1'($urandom),
                    16'($urandom), pad, nsend, 1'b0, $urandom_range(1, n + 4));
         b2b = !trunc && ($urandom_range(0, 2) == 0) && (i != 59);
         prev_b2b = b2b ? 1 : 0;
         if (!b2b) begin
            idle(2);
            drain();
         end
      end

      // frame counter wrap: 256 back-to-back 8-bit frames
      do_reset();
      send_frame(1, 2'd0, 1'b0, 1'b1, 1'b0, 16'($urandom), 16'h0, 8, 1'b0, -1);
      for (int i = 1; i < 256; i++)
         send_frame(0, 2'd0, 1'b0, 1'b0, 1'b0, 16'($urandom), 16'h0, 8, 1'b0, -1);
      idle(2); drain();
      check("wrap_cnt", frame_cnt, 0);

      // reset in the middle of a frame
      send_frame(1, 2'd1, 1'b0, 1'b1, 1'b0, 16'hFACE, 16'h0, 16, 1'b0, -1);
      idle(2); drain();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         si_valid = 1'b1;
         si_data  = 1'($urandom);
      end
      @(posedge clk);
      #2 reset = 1'b0;
      #1 check_all_zero("midrst");
      @(negedge clk);
      si_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      model_clear();
      idle(3); drain();

      // back-to-back 24-bit frames, the second one marked as last
      send_frame(1, 2'd2, 1'($urandom), 1'($urandom), 1'b0, 16'($urandom), 16'h0, 24, 1'b0, -1);
      send_frame(0, 2'd2, 1'b0, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 24, 1'b1, -1);
      idle(2);
      #1;
      if (mon_q.size() == 2) check("spacing", mon_q[1].cyc - mon_q[0].cyc, 24);
      else                   check("spacing_n", mon_q.size(), 2);
      drain();
      check("fin_cnt", frame_cnt, 2);

      // everything is ignored once finished
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         si_valid   = 1'b1;
         si_data    = 1'($urandom);
         cfg_load   = 1'($urandom);
         cfg_length = 2'($urandom);
      end
      idle(2); drain();
      check("fin_hold_cnt", frame_cnt, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
